// File: rtl/tdm_demux_2ch.sv
// tdm_demux_2ch: two-slot TDM demultiplexer with frame-sync tracking and per-channel strobes
module tdm_demux_2ch #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VALID,
  input  logic             SYNC,
  output logic [WIDTH-1:0] OUT0,
  output logic [WIDTH-1:0] OUT1,
  output logic             STB0,
  output logic             STB1,
  output logic             LOCKED,
  output logic             ERR
);
  typedef enum logic [1:0] {HUNT, SLOT0, SLOT1} state_t;
  state_t state, state_n;
  logic wr0, wr1, err_n;
  // A SYNC word always lands in channel 0; a plain word only lands in channel 1 when slot 1 is expected
  always_comb begin
    wr0     = VALID & SYNC;
    wr1     = VALID & ~SYNC & (state == SLOT1);
    err_n   = VALID & (SYNC ? (state == SLOT1) : (state != SLOT1));
    state_n = !VALID ? state : SYNC ? SLOT1 : (state == SLOT1) ? SLOT0 : HUNT;
  end
  // State, channel registers and one-cycle pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= HUNT;
      OUT0  <= '0;
      OUT1  <= '0;
      STB0  <= 1'b0;
      STB1  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_n;
      if (wr0) OUT0 <= DIN;
      if (wr1) OUT1 <= DIN;
      STB0  <= wr0;
      STB1  <= wr1;
      ERR   <= err_n;
    end
  end
  assign LOCKED = (state != HUNT);
endmodule

// File: tb/tb_tdm_demux_2ch.sv
// tb_tdm_demux_2ch: scoreboard bench for the two-slot TDM demultiplexer
module tb_tdm_demux_2ch;
  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b1;
  logic [3:0] din = '0;
  logic valid = 1'b0, sync = 1'b0;
  logic [3:0] out0, out1;
  logic stb0, stb1, locked, err;
  int checks = 0, errors = 0;

  typedef struct {
    logic [3:0] o0, o1;
    logic s0, s1, lk, er;
  } exp_t;
  exp_t sb[$];

  int m_st = 0;
  logic [3:0] m_o0 = '0, m_o1 = '0;

  tdm_demux_2ch #(.WIDTH(4)) dut (
    .CLK(clk), .RST(rst), .DIN(din), .VALID(valid), .SYNC(sync),
    .OUT0(out0), .OUT1(out1), .STB0(stb0), .STB1(stb1), .LOCKED(locked), .ERR(err)
  );

  initial forever #5 clk = clk_en ? ~clk : clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".out0"}, 32'(out0), 32'(e.o0));
    chk({tag, ".out1"}, 32'(out1), 32'(e.o1));
    chk({tag, ".stb0"}, 32'(stb0), 32'(e.s0));
    chk({tag, ".stb1"}, 32'(stb1), 32'(e.s1));
    chk({tag, ".locked"}, 32'(locked), 32'(e.lk));
    chk({tag, ".err"}, 32'(err), 32'(e.er));
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.o0 = '0; e.o1 = '0; e.s0 = 0; e.s1 = 0; e.lk = 0; e.er = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_st = 0; m_o0 = '0; m_o1 = '0;
  endtask

  // m_st: 0 = hunting, 1 = expecting slot 0, 2 = expecting slot 1
  task automatic step(input string tag, input logic v, input logic s, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    valid = v; sync = s; din = d;
    e = zero_exp();
    if (v) begin
      if (s) begin
        e.er = (m_st == 2); m_o0 = d; e.s0 = 1; m_st = 2;
      end else if (m_st == 2) begin
        m_o1 = d; e.s1 = 1; m_st = 1;
      end else begin
        e.er = 1; m_st = 0;
      end
    end
    e.o0 = m_o0; e.o1 = m_o1; e.lk = (m_st != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else chk_all(tag, sb.pop_front());
  endtask

  initial begin
    #3;
    chk_all("rst_noclk", zero_exp());
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step("rst_rel", 0, 0, 4'h0);
    // unsynced start then first sync word
    step("unsync", 1, 0, 4'h7);
    step("sync2", 1, 1, 4'h2);
    step("s1_a", 1, 0, 4'hA);
    // nominal back-to-back frames
    step("nom3", 1, 1, 4'h3);
    step("nomA", 1, 0, 4'hA);
    step("nom5", 1, 1, 4'h5);
    step("nomC", 1, 0, 4'hC);
    // gapped frames, SYNC toggled during gaps to prove it is ignored
    step("g3", 1, 1, 4'h3);
    for (int i = 0; i < 3; i++) step("gap", 0, i[0], 4'hF);
    step("gA", 1, 0, 4'hA);
    for (int i = 0; i < 3; i++) step("gap", 0, 1, 4'hE);
    step("g5", 1, 1, 4'h5);
    for (int i = 0; i < 3; i++) step("gap", 0, 0, 4'hD);
    step("gC", 1, 0, 4'hC);
    // premature sync, then missing sync
    step("pre1", 1, 1, 4'h1);
    step("pre9", 1, 1, 4'h9);
    step("preB", 1, 0, 4'hB);
    step("miss", 1, 0, 4'h4);
    step("hunt", 1, 0, 4'h8);
    // asynchronous reset between slot 0 and slot 1
    step("mid0", 1, 1, 4'h6);
    @(negedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all("rst_mid", zero_exp());
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1, 0, 4'h6);
    step("post_sync", 1, 1, 4'hE);
    // randomized traffic against the model
    repeat (300) step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux_2ch.md
# tdm_demux_2ch

Two-channel time-division demultiplexer: the receive-side counterpart of the 2:1 selector. Words arrive on a single shared bus, tagged only by a frame-sync marker. The block tracks the slot position with a small state machine and steers each word into one of two registered output channels, each with a one-cycle update strobe. It sits between the shared controller bus and the per-channel consumers (e.g. display/timer logic) in the microwave datapath.

## Interface
- WIDTH, 4, data width of the shared bus and of each output channel
- CLK  input  1  system clock; all state changes on rising edge
- RST  input  1  asynchronous, active-high reset
- DIN  input  WIDTH  shared data word
- VALID  input  1  DIN carries a word this cycle
- SYNC  input  1  qualifies the current word as slot 0 of a frame; ignored when VALID=0
- OUT0  output  WIDTH  last word delivered to channel 0 (registered, held)
- OUT1  output  WIDTH  last word delivered to channel 1 (registered, held)
- STB0  output  1  one-cycle pulse: OUT0 updated at the preceding edge
- STB1  output  1  one-cycle pulse: OUT1 updated at the preceding edge
- LOCKED  output  1  high while frame alignment is held (state SLOT0 or SLOT1)
- ERR  output  1  one-cycle pulse on alignment error or dropped word

## Operation
- States: HUNT (unsynchronised), SLOT0 (expect slot-0 word), SLOT1 (expect slot-1 word). Encoding is free; LOCKED = (state != HUNT).
- VALID=0: no state change, no strobe, outputs hold. SYNC is ignored.
- HUNT:
  - VALID & SYNC: write OUT0 <= DIN, pulse STB0, go to SLOT1.
  - VALID & !SYNC: drop the word, pulse ERR, stay in HUNT.
- SLOT0:
  - VALID & SYNC: write OUT0, pulse STB0, go to SLOT1.
  - VALID & !SYNC: missing sync. Drop the word, pulse ERR, go to HUNT.
- SLOT1:
  - VALID & !SYNC: write OUT1 <= DIN, pulse STB1, go to SLOT0.
  - VALID & SYNC: premature sync (resync). Treat as slot 0: write OUT0, pulse STB0, pulse ERR, stay in SLOT1.
- STB0 and STB1 are never high in the same cycle. ERR can coincide with STB0 (resync case only).
- Only the addressed channel register changes; the other channel holds its value.
- No arithmetic. The slot position is 1 bit and wraps SLOT1 -> SLOT0 on each completed frame.

## Timing
- Reset values, applied asynchronously while RST=1 and independent of CLK:
  - state = HUNT
  - OUT0 = OUT1 = 0
  - STB0 = STB1 = ERR = 0
  - LOCKED = 0
- RST deasserts synchronously to the design. The first edge after release evaluates inputs normally.
- Latency: DIN/VALID/SYNC sampled at edge k. OUT*, STB*, ERR and LOCKED reflect that sample after edge k, i.e. one-cycle latency.
- Strobes and ERR are registered pulses, exactly one cycle wide per qualifying input cycle. Back-to-back VALID cycles produce back-to-back strobes with no bubble.
- Throughput: one word per clock sustained.
- No combinational path from any input to any output.
- Reset mid-frame: state returns to HUNT and both channels clear. A pending slot-1 word is lost, and the next frame must start with SYNC.

## Test plan
- Reset: hold RST=1 with CLK stopped -> all outputs 0 and LOCKED=0 immediately; release -> still all 0.
- Nominal frames, WIDTH=4: (DIN=4'h3, SYNC=1), (4'hA, SYNC=0), (4'h5, SYNC=1), (4'hC, SYNC=0), VALID=1 back to back. Required response:
  - OUT0 = 3 then 5; OUT1 = A then C.
  - STB0/STB1 alternate 1,0,1,0 / 0,1,0,1.
  - LOCKED=1 from the first edge; ERR never set.
- Gaps: same frame with VALID=0 for 3 cycles between words -> identical OUT values; no strobes during gaps; state held.
- Unsynced start: VALID=1, SYNC=0, DIN=7 after reset -> ERR pulse, OUT0=OUT1=0, LOCKED=0. Then SYNC word 2 -> OUT0=2, STB0, LOCKED=1.
- Premature sync: slot-0 word 1 with SYNC, then DIN=9 with SYNC=1 -> OUT0=9, STB0 and ERR in the same cycle, OUT1 unchanged, next non-SYNC word goes to OUT1. Missing sync: a word without SYNC while in SLOT0 -> ERR pulse, LOCKED drops.
- Reset mid-frame: assert RST between a slot-0 and a slot-1 word -> OUT0=OUT1=0, LOCKED=0. A following non-SYNC word is dropped with ERR.
